// File: rtl/dmem_responder.sv
// Data-memory target: one word request at a time, LATENCY edges to a one-cycle response.
// Define DMEM_BYTE_EN to add the req_be byte-enable input for stores.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   typedef struct packed {
      logic          we;
      logic          mis;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
      logic [3:0]    be;
   } req_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        commit;
   logic [3:0]  be_in;
   req_t        cur, lat, c;
   logic [31:0] mem [DEPTH_WORDS];
   logic        unused_addr;

`ifdef DMEM_BYTE_EN
   assign be_in = req_be;
`else
   assign be_in = 4'hF;
`endif

   // Upper address bits only alias; they never reach the array.
   assign unused_addr = ^req_addr[31:AW+2];

   assign cur.we    = req_we;
   assign cur.mis   = |req_addr[1:0];
   assign cur.idx   = req_addr[AW+1:2];
   assign cur.wdata = req_wdata;
   assign cur.be    = be_in;

   // With LATENCY==1 the commit happens on the acceptance edge, before lat is loaded.
   assign c = (state == S_IDLE) ? cur : lat;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      commit     = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_nxt = CNT_INIT;
               if (LATENCY == 1) begin
                  state_nxt = S_RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = S_RESP;
               commit    = 1'b1;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && state == S_IDLE && req_valid)
         lat <= cur;
   end

   // Array is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && commit && c.we && !c.mis) begin
         for (int i = 0; i < 4; i++)
            if (c.be[i])
               mem[c.idx][8*i +: 8] <= c.wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (commit) begin
         if (c.mis) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
         end else begin
            resp_err <= 1'b0;
            if (!c.we)
               resp_rdata <= mem[c.idx];
         end
      end else if (state == S_RESP) begin
         resp_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=3 instance for the abort case.
module tb_dmem_responder;

   logic        clk;
   logic        reset, r3_reset;
   logic        req_valid, r3_valid;
   logic        req_we;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        r3_ready, r3_resp_valid, r3_err;
   logic [31:0] r3_rdata;
`ifdef DMEM_BYTE_EN
   logic [3:0]  req_be;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
      .req_be(req_be),
`endif
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) dut3 (
      .clk(clk), .reset(r3_reset), .req_valid(r3_valid), .req_ready(r3_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
      .req_be(req_be),
`endif
      .resp_valid(r3_resp_valid), .resp_rdata(r3_rdata), .resp_err(r3_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One transaction. lat counts edges from acceptance to the edge at which the
   // requester samples resp_valid high (-1 on timeout). hs_ok: ready low through
   // WAIT/RESP, then ready high and resp_valid low one cycle after the response.
   task automatic xact(input bit on3, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic err, output bit hs_ok);
      bit seen;
      lat = -1; rd = 'x; err = 1'bx; hs_ok = 1'b1; seen = 1'b0;
      if (on3) r3_valid = 1'b1; else req_valid = 1'b1;
      req_we = we; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0; r3_valid = 1'b0;
      req_we = ~we; req_addr = ~a; req_wdata = ~d;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (on3 ? r3_ready : req_ready) hs_ok = 1'b0;
         if (on3 ? r3_resp_valid : resp_valid) begin
            seen = 1'b1;
            lat  = k + 1;
            rd   = on3 ? r3_rdata : resp_rdata;
            err  = on3 ? r3_err : resp_err;
         end
         @(posedge clk); #1;
      end
      if ((on3 ? r3_resp_valid : resp_valid) !== 1'b0) hs_ok = 1'b0;
      if ((on3 ? r3_ready : req_ready) !== 1'b1) hs_ok = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; r3_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; r3_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_idle[%0d]: got rdy=%b vld=%b err=%b rd=%h want rdy=1 vld=0 err=0 rd=0",
                     i, req_ready, resp_valid, resp_err, resp_rdata);
         end
         n_cmp++;
         if ({r3_ready, r3_resp_valid, r3_err, r3_rdata} !== {3'b100, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_idle3[%0d]: got rdy=%b vld=%b err=%b rd=%h want 1/0/0/0",
                     i, r3_ready, r3_resp_valid, r3_err, r3_rdata);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_load;
      int lat; logic [31:0] rd; logic err; bit hs;
      xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, err, hs);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL st_lat: got %0d want 2", lat); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL st_err: got %b want 0", err); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL st_rdata_held: got %h want 0", rd); end
      n_cmp++; if (hs !== 1'b1) begin n_bad++; $display("FAIL st_handshake: got %b want 1", hs); end
      xact(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, err, hs);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ld_lat: got %0d want 2", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_data: got %h want deadbeef", rd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ld_err: got %b want 0", err); end
      n_cmp++; if (hs !== 1'b1) begin n_bad++; $display("FAIL ld_handshake: got %b want 1", hs); end
   endtask

   task automatic test_alias;
      int lat; logic [31:0] rd; logic err; bit hs;
      xact(1'b0, 1'b1, 32'h104, 32'h12345678, lat, rd, err, hs);
      xact(1'b0, 1'b0, 32'h004, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL alias_data: got %h want 12345678", rd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL alias_err: got %b want 0", err); end
   endtask

   task automatic test_misaligned;
      int lat; logic [31:0] rd; logic err; bit hs;
      xact(1'b0, 1'b1, 32'h22, 32'h0000AAAA, lat, rd, err, hs);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mis_lat: got %0d want 2", lat); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", err); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", rd); end
      n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL mis_err_sticky: got %b want 0", resp_err); end
      xact(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_nowrite: got %h want 0", rd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mis_next_err: got %b want 0", err); end
   endtask

   // req_valid held high: a new request is accepted every LATENCY+1 = 3 cycles.
   task automatic test_back_to_back;
      int pulses, first, second; int lat; logic [31:0] rd; logic err; bit hs;
      pulses = 0; first = -1; second = -1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h60; req_wdata = 32'h0BADF00D;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (k == 11) req_valid = 1'b0;
         if (resp_valid) begin
            pulses++;
            if (first < 0) first = k; else if (second < 0) second = k;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", pulses); end
      n_cmp++; if (second - first !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 3", second - first); end
      xact(1'b0, 1'b0, 32'h60, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL b2b_raw: got %h want 0badf00d", rd); end
   endtask

   task automatic test_reset_abort;
      int lat; int stray; logic [31:0] rd; logic err; bit hs;
      stray = 0;
      r3_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      r3_valid = 1'b0;
      n_cmp++; if (r3_ready !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", r3_ready); end
      r3_reset = 1'b1;
      @(posedge clk); #1;
      r3_reset = 1'b0;
      n_cmp++; if (r3_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", r3_ready); end
      for (int k = 0; k < 5; k++) begin
         if (r3_resp_valid) stray++;
         @(posedge clk); #1;
      end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL abort_noresp: got %0d want 0", stray); end
      xact(1'b1, 1'b0, 32'h30, 32'h0, lat, rd, err, hs);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL abort_ld_lat: got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_nowrite: got %h want 0", rd); end
   endtask

   // Reset lands exactly on the commit edge of a LATENCY=2 store.
   task automatic test_reset_commit;
      int lat; int stray; logic [31:0] rd; logic err; bit hs;
      stray = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'h11111111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (resp_valid) stray++;
         @(posedge clk); #1;
      end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL commit_rst_noresp: got %0d want 0", stray); end
      xact(1'b0, 1'b0, 32'h50, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL commit_rst_nowrite: got %h want 0", rd); end
   endtask

`ifdef DMEM_BYTE_EN
   task automatic test_byte_en;
      int lat; logic [31:0] rd; logic err; bit hs;
      req_be = 4'b1111;
      xact(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, lat, rd, err, hs);
      req_be = 4'b0101;
      xact(1'b0, 1'b1, 32'h40, 32'h00000000, lat, rd, err, hs);
      req_be = 4'b0000;
      xact(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'hFF00FF00) begin n_bad++; $display("FAIL be_merge: got %h want ff00ff00", rd); end
      xact(1'b0, 1'b1, 32'h40, 32'h12345678, lat, rd, err, hs);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL be_zero_err: got %b want 0", err); end
      xact(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, err, hs);
      n_cmp++; if (rd !== 32'hFF00FF00) begin n_bad++; $display("FAIL be_zero_noop: got %h want ff00ff00", rd); end
      req_be = 4'b1111;
   endtask
`endif

   initial begin
      reset = 1'b1; r3_reset = 1'b1;
      req_valid = 1'b0; r3_valid = 1'b0;
      req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef DMEM_BYTE_EN
      req_be = 4'b1111;
`endif
      test_reset();
      test_store_load();
      test_alias();
      test_misaligned();
      test_back_to_back();
      test_reset_abort();
      test_reset_commit();
`ifdef DMEM_BYTE_EN
      test_byte_en();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
